// File: rtl/mem_ring_pkg.sv
// mem_ring_pkg: packet encodings, field widths and slot layout for the
// circular memory ring.
package mem_ring_pkg;

   localparam int unsigned TYPE_W = 3;
   localparam int unsigned ID_W   = 5;
   localparam int unsigned ADDR_W = 36;
   localparam int unsigned DATA_W = 128;

   localparam logic [TYPE_W-1:0] EMPTY   = 3'b000;
   localparam logic [TYPE_W-1:0] WB_DATA = 3'b001;
   localparam logic [TYPE_W-1:0] RD_REQ  = 3'b011;
   localparam logic [TYPE_W-1:0] WR_ACK  = 3'b101;
   localparam logic [TYPE_W-1:0] RD_DATA = 3'b110;
   // Client-view only; never placed on the ring.
   localparam logic [TYPE_W-1:0] BUSY    = 3'b111;

   typedef struct packed {
      logic [TYPE_W-1:0] pkt_type;
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } ring_pkt_t;

   // Responses are the only packets a stop removes from the ring.
   function automatic logic is_response(input logic [TYPE_W-1:0] t);
      return (t == WR_ACK) || (t == RD_DATA);
   endfunction

endpackage

// File: rtl/ring_starve_ctr.sv
// ring_starve_ctr: counts cycles the client waits for a usable slot and
// raises a registered throttle request once the wait reaches STARVE_LIMIT.
module ring_starve_ctr #(
   parameter int unsigned STARVE_LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic cl_pending,
   input  logic legal_inject,
   output logic throttle_out
);

   logic [7:0] ctr;
   logic [7:0] ctr_next;
   logic       throttle;

   // Saturating wait counter; clears when the client is served or idle.
   always_comb begin
      ctr_next = ctr;
      if (!cl_pending || legal_inject) begin
         ctr_next = '0;
      end else if (ctr != '1) begin
         ctr_next = ctr + 8'd1;
      end
   end

   // Counter and throttle flop; throttle tracks the updated count so it
   // is visible the cycle after the count crosses the limit or clears.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctr      <= '0;
         throttle <= 1'b0;
      end else begin
         ctr      <= ctr_next;
         throttle <= (ctr_next >= 8'(STARVE_LIMIT));
      end
   end

   assign throttle_out = throttle;

endmodule

// File: rtl/mem_ring_stop.sv
// mem_ring_stop: cache-side ring stop. Registers one slot per cycle, shows it
// to the client, removes responses for NODE_ID and lets the client inject.
// Optional starvation throttle: define MEM_RING_STOP_THROTTLE_EN.
module mem_ring_stop
   import mem_ring_pkg::*;
#(
   parameter logic [4:0]  NODE_ID      = 5'd0,
   parameter int unsigned STARVE_LIMIT = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [2:0]   ring_type_in,
   input  logic [4:0]   ring_id_in,
   input  logic [35:0]  ring_addr_in,
   input  logic [127:0] ring_data_in,
   output logic [2:0]   ring_type_out,
   output logic [4:0]   ring_id_out,
   output logic [35:0]  ring_addr_out,
   output logic [127:0] ring_data_out,
   output logic [2:0]   slot_type,
   output logic [4:0]   slot_id,
   output logic [35:0]  slot_addr,
   output logic [127:0] slot_data,
   input  logic         cl_overwrite,
   input  logic [2:0]   cl_type,
   input  logic [35:0]  cl_addr,
   input  logic [127:0] cl_data,
   input  logic         cl_pending,
   input  logic         throttle_in,
   output logic         throttle_out,
   output logic         consumed,
   output logic         inject_err
);

   ring_pkt_t slot;
   ring_pkt_t pkt_out;
   logic      own;
   logic      throttled;
   logic      legal;
   logic      illegal;
   logic      err;

`ifdef MEM_RING_STOP_THROTTLE_EN
   assign throttled = throttle_in;

   ring_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_ctr (
      .clk          (clk),
      .rst          (rst),
      .cl_pending   (cl_pending),
      .legal_inject (legal),
      .throttle_out (throttle_out)
   );
`else
   logic unused_cfg;

   assign throttled    = 1'b0;
   assign throttle_out = 1'b0;
   assign unused_cfg   = &{1'b0, throttle_in, cl_pending, 8'(STARVE_LIMIT)};
`endif

   // Slot register: one hop of latency; reset discards the held slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot <= '0;
      end else begin
         slot <= '{pkt_type: ring_type_in, id: ring_id_in,
                   addr: ring_addr_in, data: ring_data_in};
      end
   end

   // Sticky error flag for dropped injections.
   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else if (illegal) begin
         err <= 1'b1;
      end
   end

   // Ownership, injection legality, client view and outgoing slot.
   always_comb begin
      own       = is_response(slot.pkt_type) && (slot.id == NODE_ID);
      legal     = cl_overwrite &&
                  (own || ((slot.pkt_type == EMPTY) && !throttled));
      illegal   = cl_overwrite && !legal;
      slot_type = slot.pkt_type;
      if ((slot.pkt_type == EMPTY) && throttled) begin
         slot_type = BUSY;
      end
      pkt_out = slot;
      if (legal) begin
         pkt_out = '{pkt_type: cl_type, id: NODE_ID, addr: cl_addr, data: cl_data};
      end else if (own) begin
         pkt_out.pkt_type = EMPTY;
      end
   end

   assign slot_id       = slot.id;
   assign slot_addr     = slot.addr;
   assign slot_data     = slot.data;
   assign ring_type_out = pkt_out.pkt_type;
   assign ring_id_out   = pkt_out.id;
   assign ring_addr_out = pkt_out.addr;
   assign ring_data_out = pkt_out.data;
   assign consumed      = own;
   assign inject_err    = err;

endmodule

// File: tb/tb_mem_ring_stop.sv
// tb_mem_ring_stop: table-driven directed vectors for mem_ring_stop
// (NODE_ID=3, STARVE_LIMIT=4) plus hand sequences for reset/inject overlap
// and the starvation throttle.
module tb_mem_ring_stop;
   import mem_ring_pkg::*;

`ifdef MEM_RING_STOP_THROTTLE_EN
   localparam logic THR_EN = 1'b1;
`else
   localparam logic THR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [2:0]   ring_type_in = '0;
   logic [4:0]   ring_id_in = '0;
   logic [35:0]  ring_addr_in = '0;
   logic [127:0] ring_data_in = '0;
   logic [2:0]   ring_type_out;
   logic [4:0]   ring_id_out;
   logic [35:0]  ring_addr_out;
   logic [127:0] ring_data_out;
   logic [2:0]   slot_type;
   logic [4:0]   slot_id;
   logic [35:0]  slot_addr;
   logic [127:0] slot_data;
   logic         cl_overwrite = 1'b0;
   logic [2:0]   cl_type = '0;
   logic [35:0]  cl_addr = '0;
   logic [127:0] cl_data = '0;
   logic         cl_pending = 1'b0;
   logic         throttle_in = 1'b0;
   logic         throttle_out;
   logic         consumed;
   logic         inject_err;

   mem_ring_stop #(
      .NODE_ID      (5'd3),
      .STARVE_LIMIT (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ring_type_in  (ring_type_in),
      .ring_id_in    (ring_id_in),
      .ring_addr_in  (ring_addr_in),
      .ring_data_in  (ring_data_in),
      .ring_type_out (ring_type_out),
      .ring_id_out   (ring_id_out),
      .ring_addr_out (ring_addr_out),
      .ring_data_out (ring_data_out),
      .slot_type     (slot_type),
      .slot_id       (slot_id),
      .slot_addr     (slot_addr),
      .slot_data     (slot_data),
      .cl_overwrite  (cl_overwrite),
      .cl_type       (cl_type),
      .cl_addr       (cl_addr),
      .cl_data       (cl_data),
      .cl_pending    (cl_pending),
      .throttle_in   (throttle_in),
      .throttle_out  (throttle_out),
      .consumed      (consumed),
      .inject_err    (inject_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      ring_pkt_t  ring;
      logic       ovw;
      logic [2:0] ct;
      logic [35:0]  ca;
      logic [127:0] cd;
      logic       thr;
      ring_pkt_t  exp_out;
      logic [2:0] exp_stype;
      logic       exp_cons;
      logic       exp_err;
   } vec_t;

   localparam int unsigned NV = 15;
   vec_t vecs[NV];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [171:0] act, input logic [171:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic ring_pkt_t pk(input logic [2:0] t, input logic [4:0] id,
                                    input logic [35:0] a, input logic [127:0] d);
      ring_pkt_t p;
      p.pkt_type = t;
      p.id       = id;
      p.addr     = a;
      p.data     = d;
      return p;
   endfunction

   function automatic vec_t mkv(input logic r, input ring_pkt_t ring, input logic ovw,
                                input logic [2:0] ct, input logic [35:0] ca,
                                input logic [127:0] cd, input logic thr,
                                input ring_pkt_t eo, input logic [2:0] es,
                                input logic ec, input logic ee);
      vec_t v;
      v.rst = r; v.ring = ring; v.ovw = ovw; v.ct = ct; v.ca = ca; v.cd = cd;
      v.thr = thr; v.exp_out = eo; v.exp_stype = es; v.exp_cons = ec; v.exp_err = ee;
      return v;
   endfunction

   ring_pkt_t act_out;
   ring_pkt_t exp_slot;

   initial begin
      logic [35:0]  a1, a2, a3, a4, a5;
      logic [127:0] d1, d2, d3, d4, d5;
      ring_pkt_t    e0, rack3, rack4, rdat3, rreq3, rwb7, rwr4, rdat5;
      a1 = 36'h012345678; d1 = 128'hC0FFEE00_11112222_33334444_55556666;
      a2 = 36'hA00000010; d2 = 128'hDEADBEEF_00000000_00000000_00000001;
      a3 = 36'h0000BEEF0; d3 = 128'h0BADF00D_0BADF00D_0BADF00D_0BADF00D;
      a4 = 36'h7FFFFFFF8; d4 = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
      a5 = 36'h123000456; d5 = 128'h00000000_AAAAAAAA_55555555_12345678;
      e0    = pk(EMPTY,   5'd0, '0, '0);
      rack3 = pk(WR_ACK,  5'd3, a2, d2);
      rack4 = pk(WR_ACK,  5'd4, a2, d2);
      rdat3 = pk(RD_DATA, 5'd3, a4, d4);
      rreq3 = pk(RD_REQ,  5'd3, a4, d4);
      rwb7  = pk(WB_DATA, 5'd7, a5, d5);
      rwr4  = pk(WR_ACK,  5'd4, a5, d5);
      rdat5 = pk(RD_DATA, 5'd5, a3, d3);

      vecs[0]  = mkv(1, e0,    0, 3'b000, '0, '0, 0, e0, 3'b000, 0, 0);
      vecs[1]  = mkv(0, e0,    1, RD_REQ, a1, d1, 0, pk(RD_REQ, 5'd3, a1, d1), 3'b000, 0, 0);
      vecs[2]  = mkv(0, rack3, 0, 3'b000, '0, '0, 0, pk(EMPTY, 5'd3, a2, d2), WR_ACK, 1, 0);
      vecs[3]  = mkv(0, rack3, 1, RD_REQ, a3, d3, 0, pk(RD_REQ, 5'd3, a3, d3), WR_ACK, 1, 0);
      vecs[4]  = mkv(0, rack4, 0, 3'b000, '0, '0, 0, rack4, WR_ACK, 0, 0);
      vecs[5]  = mkv(0, rdat3, 0, 3'b000, '0, '0, 0, pk(EMPTY, 5'd3, a4, d4), RD_DATA, 1, 0);
      vecs[6]  = mkv(0, rdat3, 1, WB_DATA, a1, d5, 0, pk(WB_DATA, 5'd3, a1, d5), RD_DATA, 1, 0);
      vecs[7]  = mkv(0, rreq3, 0, 3'b000, '0, '0, 0, rreq3, RD_REQ, 0, 0);
      vecs[8]  = mkv(0, rwb7,  1, RD_REQ, a1, d1, 0, rwb7, WB_DATA, 0, 0);
      vecs[9]  = mkv(0, pk(EMPTY, 5'd9, a3, d3), 0, 3'b000, '0, '0, 0,
                     pk(EMPTY, 5'd9, a3, d3), 3'b000, 0, 1);
      vecs[10] = mkv(0, rwr4,  1, RD_REQ, a1, d1, 0, rwr4, WR_ACK, 0, 1);
      vecs[11] = mkv(0, e0,    0, 3'b000, '0, '0, 1, e0, THR_EN ? BUSY : EMPTY, 0, 1);
      vecs[12] = mkv(0, e0,    1, RD_REQ, a2, d3, 1,
                     THR_EN ? e0 : pk(RD_REQ, 5'd3, a2, d3), THR_EN ? BUSY : EMPTY, 0, 1);
      vecs[13] = mkv(1, rdat3, 0, 3'b000, '0, '0, 0, e0, 3'b000, 0, 0);
      vecs[14] = mkv(0, rdat5, 0, 3'b000, '0, '0, 0, rdat5, RD_DATA, 0, 0);

      // Table: ring_in loaded at the edge, client inputs applied after it.
      for (int i = 0; i < NV; i++) begin
         rst          = vecs[i].rst;
         ring_type_in = vecs[i].ring.pkt_type;
         ring_id_in   = vecs[i].ring.id;
         ring_addr_in = vecs[i].ring.addr;
         ring_data_in = vecs[i].ring.data;
         @(posedge clk);
         #1;
         rst          = 1'b0;
         cl_overwrite = vecs[i].ovw;
         cl_type      = vecs[i].ct;
         cl_addr      = vecs[i].ca;
         cl_data      = vecs[i].cd;
         throttle_in  = vecs[i].thr;
         #1;
         act_out  = pk(ring_type_out, ring_id_out, ring_addr_out, ring_data_out);
         exp_slot = vecs[i].rst ? e0 : vecs[i].ring;
         check($sformatf("v%0d ring_out", i), 172'(act_out), 172'(vecs[i].exp_out));
         check($sformatf("v%0d slot_type", i), 172'(slot_type), 172'(vecs[i].exp_stype));
         check($sformatf("v%0d slot_fields", i), {slot_id, slot_addr, slot_data},
               {exp_slot.id, exp_slot.addr, exp_slot.data});
         check($sformatf("v%0d consumed", i), 172'(consumed), 172'(vecs[i].exp_cons));
         check($sformatf("v%0d inject_err", i), 172'(inject_err), 172'(vecs[i].exp_err));
         check($sformatf("v%0d throttle_out", i), 172'(throttle_out), 172'(0));
      end

      // Reset together with an own-slot injection.
      cl_overwrite = 1'b0;
      throttle_in  = 1'b0;
      ring_type_in = WB_DATA; ring_id_in = 5'd7; ring_addr_in = a5; ring_data_in = d5;
      @(posedge clk); #1;
      cl_overwrite = 1'b1; cl_type = RD_REQ; cl_addr = a1; cl_data = d1;
      ring_type_in = WR_ACK; ring_id_in = 5'd3; ring_addr_in = a2; ring_data_in = d2;
      @(posedge clk); #1;
      check("seq_err_set", 172'(inject_err), 172'(1));
      rst = 1'b1;
      #1;
      check("seq_rst_inject_out", {ring_type_out, ring_id_out, ring_addr_out, ring_data_out},
            {RD_REQ, 5'd3, a1, d1});
      check("seq_rst_inject_cons", 172'(consumed), 172'(1));
      @(posedge clk); #1;
      rst = 1'b0; cl_overwrite = 1'b0;
      #1;
      check("seq_rst_err_clear", 172'(inject_err), 172'(0));
      check("seq_rst_slot_empty", 172'(slot_type), 172'(EMPTY));
      check("seq_rst_ring_empty", 172'(ring_type_out), 172'(EMPTY));

      // Starvation throttle with STARVE_LIMIT=4.
      ring_type_in = EMPTY; ring_id_in = '0; ring_addr_in = '0; ring_data_in = '0;
      cl_pending = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         check($sformatf("thr_rise_c%0d", k), 172'(throttle_out), 172'(THR_EN && (k == 4)));
      end
      cl_overwrite = 1'b1; cl_type = RD_REQ;
      @(posedge clk); #1;
      cl_overwrite = 1'b0;
      check("thr_fall_after_inject", 172'(throttle_out), 172'(0));
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         check($sformatf("thr_rerise_c%0d", k), 172'(throttle_out), 172'(THR_EN && (k == 4)));
      end
      throttle_in = 1'b1;
      #1;
      check("thr_busy_view", 172'(slot_type), 172'(THR_EN ? BUSY : EMPTY));
      cl_pending = 1'b0;
      throttle_in = 1'b0;
      @(posedge clk); #1;
      check("thr_fall_idle", 172'(throttle_out), 172'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_ring_stop.md
# mem_ring_stop

- Cache-side stop on the circular memory ring; the data cache controller is its client.
- Each cycle the stop registers one ring slot and shows it to the client. The client can inject a packet into that slot.
- Responses addressed to this node are removed from the ring.
- An optional starvation throttle keeps upstream stops from taking every free slot.

## Interface
- NODE_ID, 0: 5-bit ring id of this stop. It is stamped into the id field of every injected packet.
- STARVE_LIMIT, 16: cycles the client may wait before the stop requests a throttle. Legal range 1..255.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ring_type_in / ring_id_in / ring_addr_in / ring_data_in  in  3/5/36/128  slot arriving from the upstream stop
- ring_type_out / ring_id_out / ring_addr_out / ring_data_out  out  3/5/36/128  slot going to the downstream stop
- slot_type / slot_id / slot_addr / slot_data  out  3/5/36/128  client view of the current slot
- cl_overwrite  in  1  client injects into the current slot
- cl_type / cl_addr / cl_data  in  3/36/128  packet the client injects
- cl_pending  in  1  client has a request waiting for a slot
- throttle_in  in  1  downstream stop is starving
- throttle_out  out  1  this stop is starving
- consumed  out  1  one-cycle pulse: a response for this node was removed
- inject_err  out  1  sticky flag: an illegal injection was dropped

## Operation

**Packet types**
- 000 EMPTY
- 001 WB_DATA
- 011 RD_REQ
- 101 WR_ACK
- 110 RD_DATA
- 111 BUSY: presented to the client only, never placed on the ring

**Slot register and client view**
- The slot register loads ring_*_in every cycle.
- slot_id, slot_addr and slot_data always equal the slot register fields.
- A slot is *own* when its type is WR_ACK or RD_DATA and its id equals NODE_ID.
- slot_type equals the slot register type, except that it reads BUSY when the slot is EMPTY and throttle_in=1. A throttled client therefore never sees a free slot.

**Injection**
- An injection is legal when cl_overwrite=1 and either:
  - the slot is own, or
  - the slot is EMPTY and throttle_in=0.
- A legal injection drives ring_*_out = {cl_type, NODE_ID, cl_addr, cl_data}.
- Inject-and-consume in the same cycle is required. The client sees an ACK or a fill beat and injects its next request into that same slot.
- An illegal injection is dropped: the output is the non-injected value and inject_err is set until rst.

**Output slot without injection**
- Own slot: ring_type_out=EMPTY. The other output fields pass the slot unchanged. consumed=1.
- Any other slot passes through unchanged, including responses for other ids and WB_DATA/RD_REQ packets.
- consumed=1 on every own slot, whether or not it is reused.

## Timing
- Combinational from slot register and client inputs: all ring_*_out, slot_*, and consumed.
- One cycle of hop latency per stop.
- Reset values:
  - slot register all zero, so slot_type=EMPTY and ring_type_out=EMPTY (when cl_overwrite=0).
  - throttle_out=0, inject_err=0, consumed=0, starvation counter=0.
- Reset mid-flight discards the held slot. Packets in other stops are unaffected.
- rst and cl_overwrite in the same cycle: the combinational output still reflects the injection; the registers reset.

## Configuration
- Macro: `MEM_RING_STOP_THROTTLE_EN`.
- Defined:
  - An 8-bit saturating counter increments each cycle that cl_pending=1 and no legal injection occurs.
  - It clears on a legal injection or when cl_pending=0.
  - throttle_out is registered: it is 1 in the cycle after the counter reaches at least STARVE_LIMIT.
  - It falls the cycle after the counter clears.
- Undefined:
  - No counter is built and throttle_out is tied to 0.
  - throttle_in is ignored: slot_type never reads BUSY and EMPTY slots are always injectable.

## Structure
- Package mem_ring_pkg holds:
  - the packet-type localparams (EMPTY, WB_DATA, RD_REQ, WR_ACK, RD_DATA, BUSY);
  - the width constants 3/5/36/128;
  - a packed struct ring_pkt_t {type, id, addr, data}.
- One sub-module, ring_starve_ctr: the counter and the throttle_out flop. It is instantiated only under the macro.

## Test plan
- Reset, then idle ring:
  - drive ring_in EMPTY and assert rst for 1 cycle;
  - required: slot_type=000, ring_type_out=000, throttle_out=0, inject_err=0.
- Empty-slot inject:
  - NODE_ID=3, ring_in EMPTY, cl_overwrite=1, cl_type=011, cl_addr=36'h12345678;
  - required: ring_out={011, 3, 36'h12345678, cl_data}, no error.
- Consume and reuse:
  - ring_in {101, id 3} with cl_overwrite=0: required consumed=1 and ring_type_out=000;
  - repeat with cl_overwrite=1, cl_type=011: required consumed=1 and ring_out={011, 3, ...};
  - same slot with id 4: required passthrough, consumed=0.
- Illegal inject:
  - ring_in {001, id 7}, cl_overwrite=1;
  - required: ring_out equals ring_in, and inject_err rises and stays 1.
- Throttle (macro on, STARVE_LIMIT=4):
  - hold cl_pending=1 with no legal injection: required throttle_out=1 in the 5th cycle;
  - one legal injection: required throttle_out=0 in the next cycle;
  - with throttle_in=1 and ring_in EMPTY: required slot_type=111.
- Macro off:
  - same stimulus as the throttle scenario;
  - required: throttle_out stays 0, and slot_type=000 on an EMPTY slot with throttle_in=1.
